// File: rtl/bp_pkg.sv
// Shared definitions for the branch direction predictor: counter constants,
// table index function (also used by the execute-stage checker) and clog2.
package bp_pkg;

  localparam int unsigned CTR_BITS_DEFAULT = 2;

  function automatic int unsigned ctrInitOf(input int unsigned bits);
    return (1 << (bits - 1)) - 1;
  endfunction

  function automatic int unsigned ctrMaxOf(input int unsigned bits);
    return (1 << bits) - 1;
  endfunction

  // Weakly not-taken start value and saturation ceiling for the default width.
  localparam int unsigned CTR_INIT = ctrInitOf(CTR_BITS_DEFAULT);
  localparam int unsigned CTR_MAX  = ctrMaxOf(CTR_BITS_DEFAULT);

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Low idxBits of the PC, XORed with the zero-extended history. ghrBits=0
  // yields a purely bimodal index.
  function automatic logic [31:0] bp_index(input logic [31:0] pc,
                                           input logic [31:0] ghr,
                                           input int unsigned idxBits,
                                           input int unsigned ghrBits);
    logic [31:0] idxMask;
    logic [31:0] ghrMask;
    idxMask = (32'd1 << idxBits) - 32'd1;
    ghrMask = (32'd1 << ghrBits) - 32'd1;
    return (pc & idxMask) ^ (ghr & ghrMask & idxMask);
  endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// One saturating up/down prediction counter; resets to weakly not-taken.
module bp_sat_ctr
  import bp_pkg::*;
#(
  parameter int unsigned CTR_BITS = CTR_BITS_DEFAULT
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                en,
  input  logic                up,
  output logic [CTR_BITS-1:0] value
);

  localparam logic [CTR_BITS-1:0] INIT_VAL = CTR_BITS'(ctrInitOf(CTR_BITS));
  localparam logic [CTR_BITS-1:0] MAX_VAL  = CTR_BITS'(ctrMaxOf(CTR_BITS));

  // NOTE: state is written with non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      value <= INIT_VAL;
    end else if (en) begin
      if (up) begin
        if (value != MAX_VAL) value <= value + CTR_BITS'(1);
      end else begin
        if (value != '0) value <= value - CTR_BITS'(1);
      end
    end
  end

endmodule

// File: rtl/branch_predictor_bht.sv
// Multi-slot branch direction predictor: table of saturating counters with
// optional gshare indexing, GHR snapshot for mispredict repair, and stats.
module branch_predictor_bht
  import bp_pkg::*;
#(
  parameter int unsigned PC_W     = 12,
  parameter int unsigned ENTRIES  = 64,
  parameter int unsigned CTR_BITS = 2,
  parameter int unsigned LOOKUPS  = 2,
  parameter int unsigned GHR_BITS = 0
) (
  input  logic                                         clock,
  input  logic                                         reset,
  input  logic [LOOKUPS-1:0]                           lookup_valid,
  input  logic [LOOKUPS*PC_W-1:0]                      lookup_pc,
  output logic [LOOKUPS-1:0]                           pred_taken,
  output logic [((GHR_BITS > 0) ? GHR_BITS : 1)-1:0]   pred_ghr,
  input  logic                                         upd_valid,
  input  logic [PC_W-1:0]                              upd_pc,
  input  logic                                         upd_taken,
  input  logic                                         upd_mispredict,
  input  logic [((GHR_BITS > 0) ? GHR_BITS : 1)-1:0]   upd_ghr,
  input  logic                                         stat_clear,
  output logic [31:0]                                  stat_lookups,
  output logic [31:0]                                  stat_mispred
);

  localparam int unsigned IDX_W = clog2(ENTRIES);
  localparam int unsigned GHR_W = (GHR_BITS > 0) ? GHR_BITS : 1;
  localparam int unsigned CNT_W = clog2(LOOKUPS + 1);
  localparam logic [CTR_BITS-1:0] CTR_HALF = CTR_BITS'(1 << (CTR_BITS - 1));
  localparam logic [31:0] STAT_MAX = 32'hFFFF_FFFF;

  logic [CTR_BITS-1:0] ctrVal [ENTRIES];
  logic [ENTRIES-1:0]  updHit;
  logic [IDX_W-1:0]    updIdx;
  logic [GHR_W-1:0]    ghrQ;
  logic [GHR_W-1:0]    ghrShifted;
  logic [GHR_W-1:0]    ghrNext;
  logic [LOOKUPS-1:0]  predRaw;
  logic [CNT_W-1:0]    effCnt;
  logic                mispredictEvt;
  logic [31:0]         statLookupsQ;
  logic [31:0]         statMispredQ;
  logic [32:0]         lookupsSum;

  assign mispredictEvt = upd_valid & upd_mispredict;

  // Training uses the history the branch was predicted with, not the live GHR.
  assign updIdx = IDX_W'(bp_index(32'(upd_pc), 32'(upd_ghr), IDX_W, GHR_BITS));

  // NOTE: the table must come up weakly not-taken, so each entry is a
  // resettable flop rather than an inferred RAM.
  for (genvar e = 0; e < ENTRIES; e++) begin : gCtr
    assign updHit[e] = upd_valid && (updIdx == IDX_W'(e));

    bp_sat_ctr #(
      .CTR_BITS(CTR_BITS)
    ) uCtr (
      .clock(clock),
      .reset(reset),
      .en   (updHit[e]),
      .up   (upd_taken),
      .value(ctrVal[e])
    );
  end

  // Slot i sees the GHR shifted by one zero per older valid slot; the first
  // predicted-taken valid slot ends the effective group.
  always_comb begin : lookupPath
    logic [GHR_W-1:0] histRun;
    logic [IDX_W-1:0] slotIdx;
    logic             alive;
    // NOTE: every always_comb output gets a default up front so no path
    // leaves it unassigned and infers a latch.
    histRun    = ghrQ;
    slotIdx    = '0;
    alive      = 1'b1;
    ghrShifted = ghrQ;
    effCnt     = '0;
    predRaw    = '0;
    for (int i = 0; i < LOOKUPS; i++) begin
      slotIdx    = IDX_W'(bp_index(32'(lookup_pc[i*PC_W +: PC_W]), 32'(histRun),
                                   IDX_W, GHR_BITS));
      predRaw[i] = lookup_valid[i] && (ctrVal[slotIdx] >= CTR_HALF);
      if (lookup_valid[i]) histRun = histRun << 1;
      if (alive && lookup_valid[i]) begin
        ghrShifted = GHR_W'({ghrShifted, predRaw[i]});
        effCnt     = effCnt + CNT_W'(1);
        alive      = ~predRaw[i];
      end
    end
  end

  assign pred_taken = predRaw & {LOOKUPS{reset}};

  // A resolved mispredict restores history and discards this cycle's lookups.
  always_comb begin
    ghrNext = ghrShifted;
    if (mispredictEvt) ghrNext = GHR_W'({upd_ghr, upd_taken});
    if (GHR_BITS == 0) ghrNext = '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ghrQ <= '0;
    end else begin
      ghrQ <= ghrNext;
    end
  end

  assign lookupsSum = {1'b0, statLookupsQ} + 33'(effCnt);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      statLookupsQ <= '0;
      statMispredQ <= '0;
    end else if (stat_clear) begin
      statLookupsQ <= '0;
      statMispredQ <= '0;
    end else begin
      if (!mispredictEvt) begin
        statLookupsQ <= lookupsSum[32] ? STAT_MAX : lookupsSum[31:0];
      end
      if (mispredictEvt && (statMispredQ != STAT_MAX)) begin
        statMispredQ <= statMispredQ + 32'd1;
      end
    end
  end

  assign pred_ghr     = ghrQ;
  assign stat_lookups = statLookupsQ;
  assign stat_mispred = statMispredQ;

endmodule
